// File: rtl/vending_status_tx.sv
// UART status transmitter: sends a 5-byte message (flag, three decimal digits, CR)
// as back-to-back 8N1 frames for a captured 7-bit credit total and dispense flag.
module vending_status_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [6:0] total,
    input  logic       water,
    output logic       TxD,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudMax = CntW'(CLKS_PER_BIT - 1);

    localparam logic [7:0] FlagWater = 8'h44;
    localparam logic [7:0] FlagTotal = 8'h54;
    localparam logic [7:0] CharCr    = 8'h0D;
    localparam logic [2:0] LastByte  = 3'd4;
    localparam logic [2:0] LastBit   = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q;
    logic [2:0]      byte_idx_q;
    logic [2:0]      bit_idx_q;
    logic [CntW-1:0] baud_q;
    logic [6:0]      total_q;
    logic            water_q;
    logic            txd_q;
    logic            busy_q;
    logic            done_q;

    logic [9:0]      bcd;
    logic [7:0]      cur_byte;
    logic            baud_end;
    logic            accept;

    // Shift-and-add-3 conversion; 127 needs only two bits for the hundreds digit.
    function automatic logic [9:0] bin2bcd(input logic [6:0] bin);
        logic [9:0] acc;
        acc = '0;
        for (int i = 6; i >= 0; i--) begin
            if (acc[3:0] >= 4'd5) acc[3:0] = acc[3:0] + 4'd3;
            if (acc[7:4] >= 4'd5) acc[7:4] = acc[7:4] + 4'd3;
            acc = {acc[8:0], bin[i]};
        end
        return acc;
    endfunction

    always_comb begin
        bcd = bin2bcd(total_q);
    end

    always_comb begin
        cur_byte = CharCr;
        case (byte_idx_q)
            3'd0:    cur_byte = water_q ? FlagWater : FlagTotal;
            3'd1:    cur_byte = {4'h3, 2'b00, bcd[9:8]};
            3'd2:    cur_byte = {4'h3, bcd[7:4]};
            3'd3:    cur_byte = {4'h3, bcd[3:0]};
            default: cur_byte = CharCr;
        endcase
    end

    assign baud_end = (baud_q == BaudMax);
    assign accept   = send & ~busy_q;

    // Outputs are registered so the start bit and busy rise together one cycle after accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            total_q    <= '0;
            water_q    <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    if (accept) begin
                        total_q    <= total;
                        water_q    <= water;
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        baud_q     <= '0;
                        txd_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        txd_q     <= cur_byte[0];
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == LastBit) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= cur_byte[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (byte_idx_q == LastByte) begin
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            txd_q      <= 1'b0;
                            state_q    <= StStart;
                        end
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign TxD  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_vending_status_tx.sv
// Bench for vending_status_tx: a mid-bit UART receiver decodes each message and compares it
// with bytes computed from the decimal value of the requested total.
module tb_vending_status_tx;

    localparam int C      = 4;
    localparam int MsgLen = 50 * C;

    logic       clk;
    logic       reset;
    logic       send;
    logic [6:0] tot;
    logic       wat;
    logic       TxD;
    logic       busy;
    logic       done;

    int         n_total;
    int         n_bad;
    logic       txd_log [MsgLen];
    int         busy_cnt;
    int         done_cnt;
    logic [7:0] rx [5];
    bit         frm_ok;

    vending_status_tx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .send (send),
        .total(tot),
        .water(wat),
        .TxD  (TxD),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] model_msg(input int t, input bit w);
        logic [7:0] flag;
        flag = w ? 8'h44 : 8'h54;
        return {flag, 8'(48 + t / 100), 8'(48 + (t / 10) % 10), 8'(48 + t % 10), 8'h0D};
    endfunction

    // Starts a request; returns at the negedge of the first message cycle.
    task automatic kick(input int t, input bit w);
        send = 1'b1;
        tot  = 7'(t);
        wat  = w;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic capture(input bit disturb);
        int base;
        busy_cnt = 0;
        done_cnt = 0;
        for (int n = 0; n < MsgLen; n++) begin
            txd_log[n] = TxD;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (disturb) begin
                if (n == 37 || n == 111) begin
                    send = 1'b1;
                    tot  = 7'($urandom);
                    wat  = 1'($urandom);
                end else if (n == 38 || n == 112) begin
                    send = 1'b0;
                end
            end
            @(negedge clk);
        end
        frm_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            base = k * 10 * C;
            if (txd_log[base + C / 2] !== 1'b0 || txd_log[base + 9 * C + C / 2] !== 1'b1)
                frm_ok = 1'b0;
            for (int j = 0; j < 8; j++) rx[k][j] = txd_log[base + (j + 1) * C + C / 2];
        end
    endtask

    // Called at the negedge of the cycle right after the last stop bit.
    task automatic expect_msg(input string tag, input int t, input bit w);
        chk({tag, ".frame"}, 64'(frm_ok), 64'd1);
        chk({tag, ".bytes"}, 64'({rx[0], rx[1], rx[2], rx[3], rx[4]}), 64'(model_msg(t, w)));
        chk({tag, ".busy_len"}, 64'(busy_cnt), 64'(MsgLen));
        chk({tag, ".early_done"}, 64'(done_cnt), 64'd0);
        chk({tag, ".done_pulse"}, 64'(done), 64'd1);
        chk({tag, ".done_busy"}, 64'(busy), 64'd0);
        chk({tag, ".done_txd"}, 64'(TxD), 64'd1);
    endtask

    initial begin
        int t;
        bit w;
        int cnt;
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        send    = 1'b0;
        tot     = '0;
        wat     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst.txd", 64'(TxD), 64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle.txd", 64'(TxD), 64'd1);

        kick(45, 1'b1);
        capture(1'b0);
        expect_msg("t45", 45, 1'b1);
        @(negedge clk);
        chk("t45.done_drop", 64'(done), 64'd0);

        kick(127, 1'b0);
        capture(1'b0);
        expect_msg("t127", 127, 1'b0);
        @(negedge clk);
        kick(0, 1'b0);
        capture(1'b0);
        expect_msg("t0", 0, 1'b0);
        @(negedge clk);

        // Input changes and send pulses mid-message must be ignored.
        t = int'($urandom_range(0, 127));
        w = 1'($urandom);
        kick(t, w);
        capture(1'b1);
        expect_msg("ignore", t, w);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) cnt++;
        end
        chk("ignore.no_second", 64'(cnt), 64'd0);

        // Held send: second message starts from the done cycle.
        send = 1'b1;
        tot  = 7'd88;
        wat  = 1'b0;
        @(negedge clk);
        capture(1'b0);
        expect_msg("held1", 88, 1'b0);
        tot = 7'd19;
        wat = 1'b1;
        @(negedge clk);
        send = 1'b0;
        chk("held.restart_busy", 64'(busy), 64'd1);
        capture(1'b0);
        expect_msg("held2", 19, 1'b1);
        @(negedge clk);
        chk("held.done_drop", 64'(done), 64'd0);

        // Abort at cycle 90 of a message.
        kick(63, 1'b1);
        repeat (89) @(negedge clk);
        chk("abort.pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.txd", 64'(TxD), 64'd1);
        chk("abort.busy", 64'(busy), 64'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (MsgLen) begin
            @(negedge clk);
            if (busy || done || !TxD) cnt++;
        end
        chk("abort.quiet", 64'(cnt), 64'd0);
        kick(99, 1'b0);
        capture(1'b0);
        expect_msg("after_abort", 99, 1'b0);
        @(negedge clk);

        // Reset wins over a simultaneous send.
        reset = 1'b1;
        send  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send  = 1'b0;
        chk("rst_prio.busy", 64'(busy), 64'd0);
        chk("rst_prio.txd", 64'(TxD), 64'd1);
        @(negedge clk);
        chk("rst_prio.still_idle", 64'(busy), 64'd0);

        for (int s = 0; s < 128; s++) begin
            w = 1'($urandom);
            kick(s, w);
            capture(1'b0);
            expect_msg($sformatf("sweep%0d", s), s, w);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
